mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Bus initiator for the data memory port: on a start strobe it copies a block of in_len words from in_src to in_dst, one word at a time.
- It drives the memory's read/write strobes, address and write data, and consumes its registered read data.
- Sits beside the datapath as a block-move helper and shares the data memory port through an upstream mux (mux is out of scope).
- Forward copy order only: ascending addresses.

Parameters:
ADDR_W, 32, width of addresses and memory address port
DATA_W, 32, width of data words
LEN_W, 16, width of transfer length and word counter
READ_LATENCY, 1, cycles from read strobe sampled to read data valid; legal 1..4

Ports:
clk  input  1  clock; all state updates on posedge
in_rst_n  input  1  synchronous active-low reset
in_start  input  1  start request; accepted only in IDLE
in_src  input  ADDR_W  source base word address, sampled on accept
in_dst  input  ADDR_W  destination base word address, sampled on accept
in_len  input  LEN_W  word count, sampled on accept
out_busy  output  1  high whenever state != IDLE
out_done  output  1  one-cycle pulse at completion
out_count  output  LEN_W  words written so far in the current or last transfer
out_mem_read  output  1  memory read strobe
out_mem_write  output  1  memory write strobe
out_mem_addr  output  ADDR_W  memory address
out_mem_wdata  output  DATA_W  memory write data
in_mem_rdata  input  DATA_W  memory read data (registered in memory, held until next read)

Behaviour:
- Reset: synchronous and active-low. When in_rst_n is sampled low at a posedge, the block enters IDLE and clears out_busy, out_done and out_count to 0. Internal src/dst/len/index registers clear to 0.
- While in_rst_n is low, out_mem_read and out_mem_write are forced to 0 combinationally, so a reset mid-transfer issues no further access in the same cycle.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - Memory strobes are 0; out_mem_addr and out_mem_wdata are 0.
  - When in_start=1, the block latches src/dst/len, clears the index and out_count, and moves to RD, or to DONE if in_len=0.
- RD: out_mem_read=1, out_mem_addr = src+idx. Next state is WAIT if READ_LATENCY>1, else WR.
- WAIT: strobes are 0. The block stays for READ_LATENCY-1 cycles (internal latency counter), then moves to WR.
- WR:
  - out_mem_write=1, out_mem_addr = dst+idx, out_mem_wdata = in_mem_rdata (passed through directly; the memory holds its read data).
  - At the edge: idx+1 and out_count+1.
  - If idx+1 == len, go to DONE; else go to RD.
- DONE: out_done=1 for exactly this cycle, strobes are 0; next state is IDLE.
- Strobes are decoded from state; out_mem_read and out_mem_write are never high in the same cycle.
- Throughput: (1+READ_LATENCY) cycles per word. With the defaults, out_busy is high for 2N+1 cycles for a len of N.
- Address arithmetic wraps modulo 2^ADDR_W. The index runs 0..len-1; len = 2^LEN_W-1 is the maximum.
- in_start while busy is ignored: inputs are not re-sampled and no error is raised.
- Overlapping regions: strictly forward read-then-write per word. Results follow sequential semantics, e.g. dst=src+1 replicates the first word.
- out_count holds its final value after DONE until the next accepted start or reset.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output port out_checksum (DATA_W), the sum modulo 2^DATA_W of every word written, updated at each WR edge.
  - Cleared to 0 on accepted start and on reset; holds after DONE.
- When undefined: the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Preload mem[i]=i. Reset, then start src=0x100 dst=0x200 len=8 → mem[0x200..0x207]=0x100..0x107; busy for 17 cycles; one done pulse; out_count=8; read/write never overlap.
- start with len=0 → DONE on the cycle after accept, done pulses once, no read/write strobe, out_count=0.
- in_start pulsed mid-transfer with src=0x300 → ignored; the original transfer completes unchanged, no access to 0x300.
- in_rst_n low for 1 cycle after the 3rd WR of an 8-word copy → strobes 0 in the reset cycle, then IDLE, out_count=0, mem[0x203..0x207] unchanged.
- Overlap: src=0x40 dst=0x41 len=4 → mem[0x41..0x44] all = 0x40.
- READ_LATENCY=3, src=0xFFFFFFFF dst=0x10 len=2 → reads at 0xFFFFFFFF then 0x0, each WR exactly 3 cycles after its RD. With MEM_COPY_CHECKSUM_EN, out_checksum = sum of the two words copied.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: forward block-copy bus initiator; define MEM_COPY_CHECKSUM_EN to add out_checksum
module mem_copy_engine #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_start,
    input  logic [ADDR_W-1:0] in_src,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out_busy,
    output logic              out_done,
    output logic [LEN_W-1:0]  out_count,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_wdata,
    input  logic [DATA_W-1:0] in_mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] out_checksum
`endif
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    // WAIT lasts READ_LATENCY-1 cycles, so the counter starts one below that
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 2);

    logic [2:0]        state;
    logic [2:0]        lat;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  idx;

    // copy sequencer: one read, optional latency wait, one write per word
    always_ff @(posedge clk) begin
        if (!in_rst_n) begin
            state     <= S_IDLE;
            lat       <= '0;
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            idx       <= '0;
            out_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_start) begin
                    src       <= in_src;
                    dst       <= in_dst;
                    len       <= in_len;
                    idx       <= '0;
                    out_count <= '0;
                    state     <= (in_len == '0) ? S_DONE : S_RD;
                end
                S_RD: begin
                    lat   <= LAT_INIT;
                    state <= (READ_LATENCY > 1) ? S_WAIT : S_WR;
                end
                S_WAIT: begin
                    lat   <= lat - 3'd1;
                    state <= (lat == '0) ? S_WR : S_WAIT;
                end
                S_WR: begin
                    idx       <= idx + LEN_W'(1);
                    out_count <= out_count + LEN_W'(1);
                    state     <= (idx + LEN_W'(1) == len) ? S_DONE : S_RD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    // running sum of every word written in the current transfer
    always_ff @(posedge clk) begin
        if (!in_rst_n)
            out_checksum <= '0;
        else if (state == S_IDLE && in_start)
            out_checksum <= '0;
        else if (state == S_WR)
            out_checksum <= out_checksum + in_mem_rdata;
    end
`endif

    assign out_busy      = state != S_IDLE;
    assign out_done      = state == S_DONE;
    assign out_mem_read  = in_rst_n && state == S_RD;
    assign out_mem_write = in_rst_n && state == S_WR;
    assign out_mem_addr  = (state == S_RD) ? src + ADDR_W'(idx) :
                           (state == S_WR) ? dst + ADDR_W'(idx) : '0;
    assign out_mem_wdata = (state == S_WR) ? in_mem_rdata : '0;
endmodule
